mem_dma: RTL and testbench
==========================

MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 The module SHALL have parameter len_width, default 16, giving the word-count width.
REQ-002 The module SHALL have parameter timeout, default 255, giving the maximum cycles to wait for mem_ready per access.
REQ-003 The module SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have the port clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The module SHALL have the port start, input, 1 bit: one-cycle pulse that launches a copy; it SHALL be honoured only in IDLE.
REQ-006 The module SHALL have the port src_addr, input, 32 bits: word-aligned source byte address.
REQ-007 The module SHALL have the port dst_addr, input, 32 bits: word-aligned destination byte address.
REQ-008 The module SHALL have the port length, input, len_width bits: number of 32-bit words to copy.
REQ-009 The module SHALL have the port busy, output, 1 bit: high while not in IDLE.
REQ-010 The module SHALL have the port done, output, 1 bit: one-cycle pulse when a copy finishes.
REQ-011 The module SHALL have the port error, output, 1 bit: sticky, set on mem_error or timeout, cleared by the next accepted start.
REQ-012 The module SHALL have the port dma_out, output, mem_in_type: request to the memory responder.
REQ-013 The module SHALL have the port dma_in, input, mem_out_type: response from the memory responder.

Function
REQ-014 The FSM SHALL have the states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.
REQ-015 In IDLE, start=1 with length=0 SHALL go straight to FINISH; start with length>0 SHALL latch src, dst and count, clear error, and go to RD_REQ.
REQ-016 In RD_REQ, the module SHALL drive mem_valid=1, mem_addr=src, mem_wstrb=0 and mem_wdata=0 for exactly one cycle, then go to RD_WAIT.
REQ-017 In RD_WAIT, mem_valid SHALL be 0; on mem_ready=1 the module SHALL capture mem_rdata into a 32-bit data register and go to WR_REQ.
REQ-018 In WR_REQ, the module SHALL drive mem_valid=1, mem_addr=dst, mem_wstrb=4'hF and mem_wdata equal to the data register for one cycle, then go to WR_WAIT.
REQ-019 In WR_WAIT, on mem_ready=1 the module SHALL add 4 to src and to dst (32-bit wrap-around, no carry out) and decrement count; when count reaches 0 it SHALL go to FINISH, otherwise to RD_REQ.
REQ-020 FINISH SHALL pulse done=1 for one cycle and return to IDLE.
REQ-021 mem_error=1 together with mem_ready in RD_WAIT or WR_WAIT SHALL set error and go to FINISH with no further accesses; in RD_WAIT the data SHALL be discarded.
REQ-022 A wait counter SHALL reset on entry to each WAIT state; reaching timeout without mem_ready SHALL set error and go to FINISH.
REQ-023 Each word SHALL take at least 4 cycles with a one-cycle-latency responder; a 0-length copy SHALL complete with done 2 cycles after start.
REQ-024 A start pulse while busy SHALL be ignored.
REQ-025 All dma_out fields not listed above SHALL be driven to 0.
REQ-026 Address bits [1:0] SHALL be forced to 0 on the bus.

Reset
REQ-027 Reset low SHALL immediately force IDLE, set busy, done and error to 0, clear all dma_out fields, and clear the data, address, count and wait-counter registers to 0.
REQ-028 Reset asserted mid-transfer SHALL abandon the copy with no done pulse.

Structure
REQ-029 The dma state enum SHALL live in configure, beside mem_in_type and mem_out_type.
REQ-030 The module SHALL be a single module with no sub-module; the integration bench SHALL pair it with the existing RAM.

Verification
REQ-031 Copy 4 words 0x0→0x100 from preloaded RAM: memory at 0x100..0x10C SHALL equal the source, done SHALL pulse once, and error SHALL be 0.
REQ-032 start with length=0: no mem_valid SHALL occur, and done SHALL pulse 2 cycles later.
REQ-033 The responder SHALL return mem_error on the 2nd read: one write SHALL be done, error=1, done SHALL pulse, and the state SHALL be IDLE.
REQ-034 The responder SHALL never assert ready with timeout=8: error SHALL set 8 cycles after RD_REQ, and done SHALL pulse.
REQ-035 Pull reset low during WR_WAIT of word 2, then release: outputs SHALL be 0, there SHALL be no done, and a fresh start SHALL copy correctly.
REQ-036 start asserted while busy: it SHALL be ignored, and the transfer count SHALL be unchanged.

Source files
------------

// File: rtl/configure.sv
// configure -- shared types for the memory bus and the DMA engine.
//
// mem_in_type  : request from a bus master to the memory responder
//                (valid, instr, byte address, write data, byte strobes).
// mem_out_type : response from the memory responder
//                (ready, error, read data).
// dma_state_type : states of the mem_dma copy engine.
package configure;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic        mem_error;
        logic [31:0] mem_rdata;
    } mem_out_type;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        FINISH
    } dma_state_type;

    localparam logic [3:0]  WSTRB_WORD = 4'hF;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    // The bus only ever carries word addresses, so the byte-offset bits are
    // cleared here rather than trusting the caller's alignment.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/mem_dma.sv
// mem_dma -- word-by-word memory-to-memory copy engine.
//
// Each word is read from src, held in a data register, then written to dst.
// A copy ends early (with error set) on a bus error or when the responder
// fails to answer within `timeout` cycles of an access.
//
// Parameters
//   len_width : width of the word count
//   timeout   : cycles to wait for mem_ready on each access before giving up
// Ports
//   clock     : single clock, rising edge
//   reset     : asynchronous, active-low
//   start     : one-cycle launch pulse, only honoured while idle
//   src_addr  : source byte address (word aligned)
//   dst_addr  : destination byte address (word aligned)
//   length    : number of 32-bit words to copy
//   busy      : high whenever the engine is not idle
//   done      : one-cycle pulse as a copy finishes
//   error     : sticky error flag, cleared by the next accepted start
//   dma_out   : request to the memory responder
//   dma_in    : response from the memory responder
module mem_dma
    import configure::*;
#(
    parameter int len_width = 16,
    parameter int timeout   = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [len_width-1:0] length,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output mem_in_type           dma_out,
    input  mem_out_type          dma_in
);

    dma_state_type        state;
    dma_state_type        next_state;
    logic [31:0]          src_reg;
    logic [31:0]          dst_reg;
    logic [31:0]          data_reg;
    logic [31:0]          wait_cnt;
    logic [len_width-1:0] count;
    logic                 timed_out;
    logic                 last_word;

    // The wait counter starts at zero on the first wait cycle, so this fires
    // on the timeout-th cycle spent waiting for a response.
    assign timed_out = (wait_cnt == 32'(timeout - 1));
    assign last_word = (count == len_width'(1));

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A response carrying mem_error, or a timeout, aborts
    // the copy straight to FINISH so no further accesses are issued.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (length == '0) ? FINISH : RD_REQ;
                end
            end
            RD_REQ:  next_state = RD_WAIT;
            RD_WAIT: begin
                if (dma_in.mem_ready) begin
                    next_state = dma_in.mem_error ? FINISH : WR_REQ;
                end else if (timed_out) begin
                    next_state = FINISH;
                end
            end
            WR_REQ:  next_state = WR_WAIT;
            WR_WAIT: begin
                if (dma_in.mem_ready) begin
                    if (dma_in.mem_error || last_word) begin
                        next_state = FINISH;
                    end else begin
                        next_state = RD_REQ;
                    end
                end else if (timed_out) begin
                    next_state = FINISH;
                end
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers: addresses, remaining count, read data, wait
    // counter and the sticky error flag. A response with mem_error in
    // RD_WAIT leaves data_reg untouched so the bad word is never written.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            src_reg  <= '0;
            dst_reg  <= '0;
            data_reg <= '0;
            wait_cnt <= '0;
            count    <= '0;
            error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        if (length != '0) begin
                            src_reg <= src_addr;
                            dst_reg <= dst_addr;
                            count   <= length;
                        end
                    end
                end
                RD_REQ, WR_REQ: begin
                    wait_cnt <= '0;
                end
                RD_WAIT: begin
                    if (dma_in.mem_ready) begin
                        if (dma_in.mem_error) begin
                            error <= 1'b1;
                        end else begin
                            data_reg <= dma_in.mem_rdata;
                        end
                    end else if (timed_out) begin
                        error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                WR_WAIT: begin
                    if (dma_in.mem_ready) begin
                        if (dma_in.mem_error) begin
                            error <= 1'b1;
                        end else begin
                            src_reg <= src_reg + WORD_BYTES;
                            dst_reg <= dst_reg + WORD_BYTES;
                            count   <= count - len_width'(1);
                        end
                    end else if (timed_out) begin
                        error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the state. Every bus field defaults to zero so
    // only the request states place anything on the bus.
    always_comb begin
        dma_out = '0;
        busy    = (state != IDLE);
        done    = (state == FINISH);
        case (state)
            RD_REQ: begin
                dma_out.mem_valid = 1'b1;
                dma_out.mem_addr  = word_align(src_reg);
            end
            WR_REQ: begin
                dma_out.mem_valid = 1'b1;
                dma_out.mem_addr  = word_align(dst_reg);
                dma_out.mem_wdata = data_reg;
                dma_out.mem_wstrb = WSTRB_WORD;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma -- self-checking bench for mem_dma.
//
// A 256-word RAM responder answers one cycle after each request. The
// expected behaviour of every copy is written out ahead of time as a
// cycle-by-cycle trace of outputs, built from the transfer parameters and
// the responder's known behaviour; a compare process pops one entry per
// cycle (or expects idle outputs when the trace is empty).
module tb_mem_dma;
    import configure::*;

    localparam int LEN_W = 16;
    localparam int TMO   = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] length = '0;
    logic             busy;
    logic             done;
    logic             error;
    mem_in_type       dma_out;
    mem_out_type      dma_in;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        error;
        logic        valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur_exp;
    logic        last_err = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          busy_cycles = 0;
    int          done_count = 0;
    int          read_count = 0;
    int          write_count = 0;
    int          err_at_read = 0;
    logic        resp_mute = 1'b0;
    logic [31:0] ram [256];

    mem_dma #(.len_width(LEN_W), .timeout(TMO)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .dma_out  (dma_out),
        .dma_in   (dma_in)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    function automatic exp_t mk(input logic b, input logic d, input logic er,
                                input logic v, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] ws);
        exp_t e;
        e.busy = b; e.done = d; e.error = er; e.valid = v;
        e.addr = a; e.wdata = wd; e.wstrb = ws;
        return e;
    endfunction

    // RAM responder: one-cycle latency, reloaded with a known pattern on reset.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            dma_in <= '0;
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else begin
            dma_in <= '0;
            if (dma_out.mem_valid && !resp_mute) begin
                dma_in.mem_ready <= 1'b1;
                if (dma_out.mem_wstrb == 4'h0) begin
                    dma_in.mem_rdata <= ram[dma_out.mem_addr[9:2]];
                    if (read_count + 1 == err_at_read) dma_in.mem_error <= 1'b1;
                    read_count <= read_count + 1;
                end else begin
                    ram[dma_out.mem_addr[9:2]] <= dma_out.mem_wdata;
                    write_count <= write_count + 1;
                end
            end
        end
    end

    task automatic check_output(input string name, input exp_t e);
        checks++;
        if (busy !== e.busy || done !== e.done || error !== e.error ||
            dma_out.mem_valid !== e.valid || dma_out.mem_addr !== e.addr ||
            dma_out.mem_wdata !== e.wdata || dma_out.mem_wstrb !== e.wstrb ||
            dma_out.mem_instr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s t=%0t got busy=%b done=%b err=%b valid=%b addr=%h wdata=%h wstrb=%h instr=%b, expected busy=%b done=%b err=%b valid=%b addr=%h wdata=%h wstrb=%h instr=0",
                     name, $time, busy, done, error, dma_out.mem_valid,
                     dma_out.mem_addr, dma_out.mem_wdata, dma_out.mem_wstrb,
                     dma_out.mem_instr, e.busy, e.done, e.error, e.valid,
                     e.addr, e.wdata, e.wstrb);
        end
    endtask

    task automatic check_value(input string name, input logic [31:0] act,
                               input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, act, expv);
        end
    endtask

    // Compare process: one expected entry per cycle, idle outputs otherwise.
    always @(negedge clock) begin
        cur_exp = mk(1'b0, 1'b0, last_err, 1'b0, '0, '0, '0);
        if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
        last_err = cur_exp.error;
        if (busy === 1'b1) busy_cycles++;
        if (done === 1'b1) done_count++;
        check_output("cycle", cur_exp);
    end

    // Expected trace of a copy. The first entry is the cycle in which start
    // is presented but not yet sampled. Each word: read request, one wait
    // cycle, write request, one wait cycle; then a done cycle.
    task automatic build_trace(input logic [31:0] src, input logic [31:0] dst,
                               input int len, input int err_read, input logic mute);
        logic [31:0] a_s;
        logic [31:0] a_d;
        exp_q.push_back(mk(1'b0, 1'b0, last_err, 1'b0, '0, '0, '0));
        for (int i = 0; i < len; i++) begin
            a_s = (src + 32'(4 * i)) & ~32'd3;
            a_d = (dst + 32'(4 * i)) & ~32'd3;
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, a_s, '0, 4'h0));
            if (mute) begin
                for (int w = 0; w < TMO; w++)
                    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0));
                exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, '0));
                return;
            end
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0));
            if (i + 1 == err_read) begin
                exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, '0));
                return;
            end
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, a_d, init_word(int'(a_s[9:2])), 4'hF));
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0));
        end
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0));
    endtask

    // Present a one-cycle start pulse; the model only accepts it when idle.
    task automatic apply_stimulus(input logic [31:0] src, input logic [31:0] dst,
                                  input int len, input int err_read, input logic mute);
        @(posedge clock);
        #1;
        start    = 1'b1;
        src_addr = src;
        dst_addr = dst;
        length   = LEN_W'(len);
        if (exp_q.size() == 0) build_trace(src, dst, len, err_read, mute);
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_idle got %0d pending cycles expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int b0, d0, w0, r0;
        logic found;

        #2 reset = 1'b0;
        #1 check_output("reset_now", mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0));
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        $display("[TB] 4-word copy 0x0 -> 0x100");
        b0 = busy_cycles; d0 = done_count; w0 = write_count;
        apply_stimulus(32'h0, 32'h100, 4, 0, 1'b0);
        wait_idle(200);
        check_value("copy_busy_cycles", 32'(busy_cycles - b0), 32'd17);
        check_value("copy_done_count", 32'(done_count - d0), 32'd1);
        check_value("copy_writes", 32'(write_count - w0), 32'd4);
        check_value("copy_word0", ram[64], 32'hC0DE_0000);
        check_value("copy_word3", ram[67], 32'hC0DE_0003);
        check_value("copy_error", 32'(error), 32'd0);

        $display("[TB] zero-length start");
        b0 = busy_cycles; d0 = done_count; w0 = write_count; r0 = read_count;
        apply_stimulus(32'h8, 32'h3F0, 0, 0, 1'b0);
        wait_idle(20);
        check_value("zero_busy_cycles", 32'(busy_cycles - b0), 32'd1);
        check_value("zero_done_count", 32'(done_count - d0), 32'd1);
        check_value("zero_accesses", 32'(write_count - w0 + read_count - r0), 32'd0);

        $display("[TB] start while busy is ignored");
        b0 = busy_cycles; d0 = done_count; w0 = write_count;
        apply_stimulus(32'h10, 32'h180, 4, 0, 1'b0);
        repeat (3) @(posedge clock);
        apply_stimulus(32'h300, 32'h3C0, 7, 0, 1'b0);
        wait_idle(200);
        check_value("busy_start_writes", 32'(write_count - w0), 32'd4);
        check_value("busy_start_cycles", 32'(busy_cycles - b0), 32'd17);
        check_value("busy_start_done", 32'(done_count - d0), 32'd1);
        check_value("busy_start_word3", ram[99], 32'hC0DE_0007);
        check_value("busy_start_untouched", ram[240], 32'hC0DE_00F0);

        $display("[TB] bus error on second read");
        b0 = busy_cycles; d0 = done_count; w0 = write_count;
        err_at_read = read_count + 2;
        apply_stimulus(32'h20, 32'h200, 4, 2, 1'b0);
        wait_idle(200);
        err_at_read = 0;
        check_value("buserr_writes", 32'(write_count - w0), 32'd1);
        check_value("buserr_error", 32'(error), 32'd1);
        check_value("buserr_done", 32'(done_count - d0), 32'd1);
        check_value("buserr_cycles", 32'(busy_cycles - b0), 32'd7);
        check_value("buserr_idle", 32'(busy), 32'd0);
        check_value("buserr_word0", ram[128], 32'hC0DE_0008);
        check_value("buserr_word1", ram[129], 32'hC0DE_0081);

        $display("[TB] responder never ready");
        b0 = busy_cycles; d0 = done_count; r0 = read_count;
        resp_mute = 1'b1;
        apply_stimulus(32'h40, 32'h300, 2, 0, 1'b1);
        wait_idle(200);
        resp_mute = 1'b0;
        check_value("timeout_cycles", 32'(busy_cycles - b0), 32'd10);
        check_value("timeout_error", 32'(error), 32'd1);
        check_value("timeout_done", 32'(done_count - d0), 32'd1);
        check_value("timeout_reads", 32'(read_count - r0), 32'd0);

        $display("[TB] reset during second word write wait");
        apply_stimulus(32'h50, 32'h280, 4, 0, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clock);
            if (dma_out.mem_valid && dma_out.mem_wstrb == 4'hF &&
                dma_out.mem_addr == 32'h284) found = 1'b1;
        end
        check_value("reset_reached_word2", 32'(found), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        last_err = 1'b0;
        d0 = done_count;
        #1 check_output("reset_mid", mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0));
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 check_value("reset_no_done", 32'(done_count - d0), 32'd0);

        $display("[TB] fresh copy after reset");
        w0 = write_count; d0 = done_count;
        apply_stimulus(32'h60, 32'h380, 4, 0, 1'b0);
        wait_idle(200);
        check_value("fresh_writes", 32'(write_count - w0), 32'd4);
        check_value("fresh_done", 32'(done_count - d0), 32'd1);
        check_value("fresh_word0", ram[224], 32'hC0DE_0018);
        check_value("fresh_word3", ram[227], 32'hC0DE_001B);
        check_value("fresh_error", 32'(error), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
